// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and the byte-lane enable helper for the memory slave.
package ahb_pkg;

  localparam int unsigned MAX_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  // Byte lanes touched by a transfer of 2^size bytes at the given lane offset.
  function automatic logic [MAX_BYTES-1:0] be_mask(input logic [2:0] size,
                                                   input logic [2:0] addr_lsb,
                                                   input int unsigned data_w);
    logic [MAX_BYTES-1:0] m;
    logic [2:0]           lsb;
    lsb = (data_w == 64) ? addr_lsb : {1'b0, addr_lsb[1:0]};
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    m = m << lsb;
    return m;
  endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and the memory slave.
interface ahb_mem_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_slv_lfsr.sv
// 16-bit Fibonacci LFSR that picks per-beat wait counts when
// AHB_SLV_RAND_WAIT_EN is defined. Advances once per accepted beat.
module ahb_slv_lfsr (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_adv,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_lfsr = r_lfsr;

  // Shift register, seeded on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 16'hACE1;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// Parametrised AHB-Lite memory slave: byte-lane writes, ERROR responses,
// configurable wait states and read-after-write forwarding.
// Optional feature: define AHB_SLV_RAND_WAIT_EN for LFSR-randomised wait counts.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       MEM_DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahb_mem_slave_if.slave  bus
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LSB_W = $clog2(BYTES);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_W:0] START_ADDR = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] END_ADDR   = START_ADDR + (ADDR_W+1)'(MEM_DEPTH * BYTES);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  slv_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_wr, w_wr_nxt;
  logic [IDX_W-1:0]  r_word, w_word_nxt;
  logic [BYTES-1:0]  r_be, w_be_nxt;
  logic              r_hready_out, r_hresp;
  logic [DATA_W-1:0] r_hrdata, w_hrdata_nxt;

  logic              w_open, w_accept, w_err;
  logic              w_in_range, w_size_err, w_misalign;
  logic [2:0]        w_amask;
  logic [ADDR_W-1:0] w_offs;
  logic [IDX_W-1:0]  w_word;
  logic [MAX_BYTES-1:0] w_be8;
  logic [BYTES-1:0]  w_be;
  logic              w_commit;
  logic [CNT_W-1:0]  w_wait;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused;

  // Address-phase decode: accept, error classification, word index, lanes.
  assign w_open     = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept   = w_open & bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_in_range = ({1'b0, bus.HADDR} >= START_ADDR) && ({1'b0, bus.HADDR} < END_ADDR);
  assign w_size_err = bus.HSIZE > 3'(LSB_W);
  assign w_amask    = 3'((4'd1 << bus.HSIZE[1:0]) - 4'd1);
  assign w_misalign = |(bus.HADDR[2:0] & w_amask);
  assign w_err      = ~w_in_range | w_size_err | w_misalign;
  assign w_offs     = bus.HADDR - BASE_ADDR;
  assign w_word     = IDX_W'(w_offs >> LSB_W);
  assign w_be8      = be_mask(bus.HSIZE, bus.HADDR[2:0], DATA_W);
  assign w_be       = w_be8[BYTES-1:0];
  assign w_commit   = r_pend & r_wr & (r_state == ST_IDLE);
  assign w_unused   = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0], w_be8};

`ifdef AHB_SLV_RAND_WAIT_EN
  logic [15:0] w_lfsr;

  ahb_slv_lfsr u_lfsr (
    .i_clk  (HCLK),
    .i_rst  (HRESET),
    .i_adv  (w_accept),
    .o_lfsr (w_lfsr)
  );

  assign w_wait = CNT_W'(w_lfsr % 16'(WAIT_STATES + 1));
`else
  assign w_wait = CNT_W'(WAIT_STATES);
`endif

  // Read word with the bytes of a write committing this cycle merged in.
  always_comb begin
    w_rd_word = r_mem[w_word];
    for (int b = 0; b < int'(BYTES); b++) begin
      if (w_commit && (r_word == w_word) && r_be[b]) begin
        w_rd_word[b*8 +: 8] = bus.HWDATA[b*8 +: 8];
      end
    end
  end

  // Next-state and pending-beat bookkeeping.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
    w_wr_nxt     = r_wr;
    w_word_nxt   = r_word;
    w_be_nxt     = r_be;
    w_hrdata_nxt = '0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        w_pend_nxt  = 1'b0;
        if (w_accept) begin
          w_wr_nxt   = bus.HWRITE;
          w_word_nxt = w_word;
          w_be_nxt   = w_be;
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else begin
            w_pend_nxt = 1'b1;
            if (w_wait != CNT_W'(0)) begin
              w_state_nxt = ST_WAIT;
              w_cnt_nxt   = w_wait;
            end else if (!bus.HWRITE) begin
              w_hrdata_nxt = w_rd_word;
            end
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          if (!r_wr) begin
            w_hrdata_nxt = r_mem[r_word];
          end
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_wr         <= 1'b0;
      r_word       <= '0;
      r_be         <= '0;
      r_hready_out <= 1'b1;
      r_hresp      <= OKAY;
      r_hrdata     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend       <= w_pend_nxt;
      r_wr         <= w_wr_nxt;
      r_word       <= w_word_nxt;
      r_be         <= w_be_nxt;
      r_hready_out <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERR2);
      r_hresp      <= ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ? ERROR : OKAY;
      r_hrdata     <= w_hrdata_nxt;
    end
  end

  // Memory array: contents survive reset; writes land only on enabled lanes.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_commit) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (r_be[b]) begin
          r_mem[r_word][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = r_hready_out;
  assign bus.HRESP     = r_hresp;
  assign bus.HRDATA    = r_hrdata;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: a zero-wait instance driven from a vector
// table and a three-wait instance exercised by hand-written sequences.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  assign if0.HREADY = if0.HREADYOUT;
  assign if3.HREADY = if3.HREADYOUT;

  ahb_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024),
                  .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (if0.slave)
  );

  ahb_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024),
                  .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (if3.slave)
  );

  typedef struct packed {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  function automatic vec_t mk(input logic s, input logic [1:0] t, input logic w,
                              input logic [2:0] z, input logic [31:0] a,
                              input logic [31:0] d, input logic r, input logic e,
                              input logic [31:0] q);
    return {s, t, w, z, a, d, r, e, q};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic resp,
                          input logic [31:0] rdata, input logic er, input logic ep,
                          input logic [31:0] ed);
    chk({tag, " hreadyout"}, 32'(rdy), 32'(er));
    chk({tag, " hresp"},     32'(resp), 32'(ep));
    chk({tag, " hrdata"},    rdata, ed);
  endtask

  // One NONSEQ word beat on the three-wait slave; counts HREADYOUT-low cycles.
  task automatic beat3(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input string tag);
    int lows;
    bit done;
    @(posedge HCLK); #1;
    if3.HSEL = 1'b1; if3.HTRANS = NONSEQ; if3.HWRITE = wr;
    if3.HSIZE = 3'd2; if3.HADDR = addr;
    @(posedge HCLK); #1;
    if3.HSEL = 1'b0; if3.HTRANS = IDLE; if3.HWDATA = wd;
    lows = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge HCLK);
      if (if3.HREADYOUT === 1'b1) begin
        done = 1'b1;
      end else begin
        lows++;
        @(posedge HCLK); #1;
      end
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " wait cycles"}, 32'(lows), 32'd3);
    chk({tag, " hresp"}, 32'(if3.HRESP), 32'd0);
    if (!wr) chk({tag, " hrdata"}, if3.HRDATA, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    if0.HSEL = 1'b0; if0.HTRANS = IDLE; if0.HWRITE = 1'b0; if0.HSIZE = 3'd2;
    if0.HADDR = '0; if0.HWDATA = '0; if0.HBURST = '0; if0.HPROT = '0;
    if3.HSEL = 1'b0; if3.HTRANS = IDLE; if3.HWRITE = 1'b0; if3.HSIZE = 3'd2;
    if3.HADDR = '0; if3.HWDATA = '0; if3.HBURST = '0; if3.HPROT = '0;
    HRESET = 1'b1;

    //        sel  trans   wr  sz  addr          wdata         rdy resp rdata
    vt[0]  = mk(1, NONSEQ, 1, 2, 32'h0000_0010, 32'h0,        1, 0, 32'h0);
    vt[1]  = mk(1, NONSEQ, 0, 2, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0);
    vt[2]  = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        1, 0, 32'hDEAD_BEEF);
    vt[3]  = mk(1, NONSEQ, 1, 2, 32'h0000_0010, 32'h0,        1, 0, 32'h0);
    vt[4]  = mk(1, NONSEQ, 1, 0, 32'h0000_0013, 32'h0,        1, 0, 32'h0);
    vt[5]  = mk(1, NONSEQ, 0, 2, 32'h0000_0010, 32'hA500_0000, 1, 0, 32'h0);
    vt[6]  = mk(1, NONSEQ, 1, 1, 32'h0000_0010, 32'h0,        1, 0, 32'hA500_0000);
    vt[7]  = mk(1, IDLE,   0, 2, 32'h0,         32'h1234_5678, 1, 0, 32'h0);
    vt[8]  = mk(1, NONSEQ, 0, 2, 32'h0000_0010, 32'h0,        1, 0, 32'h0);
    vt[9]  = mk(1, SEQ,    0, 0, 32'h0000_0013, 32'h0,        1, 0, 32'hA500_5678);
    vt[10] = mk(1, BUSY,   0, 2, 32'h0000_0014, 32'h0,        1, 0, 32'hA500_5678);
    vt[11] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        1, 0, 32'h0);
    vt[12] = mk(1, NONSEQ, 0, 2, 32'h0000_1000, 32'h0,        1, 0, 32'h0);
    vt[13] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        0, 1, 32'h0);
    vt[14] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        1, 1, 32'h0);
    vt[15] = mk(1, NONSEQ, 0, 2, 32'h0000_0002, 32'h0,        1, 0, 32'h0);
    vt[16] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        0, 1, 32'h0);
    vt[17] = mk(1, NONSEQ, 0, 3, 32'h0000_0010, 32'h0,        1, 1, 32'h0);
    vt[18] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        0, 1, 32'h0);
    vt[19] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        1, 1, 32'h0);
    vt[20] = mk(0, NONSEQ, 1, 2, 32'h0000_0010, 32'h0,        1, 0, 32'h0);
    vt[21] = mk(1, NONSEQ, 0, 2, 32'h0000_0010, 32'hFFFF_FFFF, 1, 0, 32'h0);
    vt[22] = mk(1, NONSEQ, 1, 2, 32'h0000_0FFC, 32'h0,        1, 0, 32'hA500_5678);
    vt[23] = mk(1, NONSEQ, 0, 2, 32'h0000_0FFC, 32'h0BAD_F00D, 1, 0, 32'h0);
    vt[24] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        1, 0, 32'h0BAD_F00D);
    vt[25] = mk(1, IDLE,   0, 2, 32'h0,         32'h0,        1, 0, 32'h0);

    // Reset held three cycles, then the first cycle after release.
    for (int c = 0; c < 4; c++) begin
      @(posedge HCLK); #1;
      if (c == 2) HRESET = 1'b0;
      @(negedge HCLK);
      chk_outs($sformatf("reset c%0d dut0", c), if0.HREADYOUT, if0.HRESP, if0.HRDATA,
               1'b1, 1'b0, 32'h0);
      chk_outs($sformatf("reset c%0d dut3", c), if3.HREADYOUT, if3.HRESP, if3.HRDATA,
               1'b1, 1'b0, 32'h0);
    end

    // Zero-wait pipelined vectors.
    for (int i = 0; i < NV; i++) begin
      @(posedge HCLK); #1;
      if0.HSEL   = vt[i].hsel;
      if0.HTRANS = vt[i].htrans;
      if0.HWRITE = vt[i].hwrite;
      if0.HSIZE  = vt[i].hsize;
      if0.HADDR  = vt[i].haddr;
      if0.HWDATA = vt[i].hwdata;
      @(negedge HCLK);
      chk_outs($sformatf("vec%0d", i), if0.HREADYOUT, if0.HRESP, if0.HRDATA,
               vt[i].exp_rdy, vt[i].exp_resp, vt[i].exp_rdata);
    end

    // Three-wait write then read back.
    beat3(1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, "ws3 write");
    beat3(1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, "ws3 read");

    // BUSY on the waited slave: OKAY with no wait.
    for (int c = 0; c < 2; c++) begin
      @(posedge HCLK); #1;
      if3.HSEL = 1'b1; if3.HTRANS = BUSY; if3.HADDR = 32'h0000_0024;
      @(negedge HCLK);
      chk_outs($sformatf("ws3 busy c%0d", c), if3.HREADYOUT, if3.HRESP, if3.HRDATA,
               1'b1, 1'b0, 32'h0);
    end

    // Reset during the wait phase of a write: nothing is committed.
    @(posedge HCLK); #1;
    if3.HSEL = 1'b1; if3.HTRANS = NONSEQ; if3.HWRITE = 1'b1; if3.HADDR = 32'h0000_0020;
    @(posedge HCLK); #1;
    if3.HSEL = 1'b0; if3.HTRANS = IDLE; if3.HWDATA = 32'hBAD0_BAD0;
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rst mid wait hreadyout before", 32'(if3.HREADYOUT), 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk_outs("rst mid wait after", if3.HREADYOUT, if3.HRESP, if3.HRDATA, 1'b1, 1'b0, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    chk("rst mid wait idle", 32'(if3.HREADYOUT), 32'd1);
    beat3(1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, "ws3 read after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
